// File: rtl/exu_alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: ALU control packet, requester id, in-flight record.
package exu_alu_arb_pkg;

    localparam int ALU_ARB_TAGW = 4;

    typedef struct packed {
        logic add;
        logic sub;
        logic land;
        logic lor;
        logic lxor;
        logic sll;
        logic srl;
        logic slt;
    } alu_pkt_t;

    typedef enum logic {
        ARB_R0 = 1'b0,
        ARB_R1 = 1'b1
    } arb_id_e;

    typedef struct packed {
        logic                    v;
        arb_id_e                 id;
        logic [ALU_ARB_TAGW-1:0] tag;
        alu_pkt_t                ap;
    } arb_inflight_t;

endpackage

// File: rtl/exu_arb_age.sv
// Saturating wait counter for requester 1; starve asserts once it has waited STARVE_LIM unfrozen cycles.
module exu_arb_age #(
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic req,
    input  logic gnt,
    output logic starve
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (!freeze && cnt != CW'(STARVE_LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve = (cnt == CW'(STARVE_LIM));

endmodule

// File: rtl/exu_alu_arb.sv
// Shares one ALU (operand flops + one-cycle result) between the issue pipe (r0) and a background sequencer (r1).
// Optional r1 anti-starvation priority boost is enabled by defining EXU_ALU_ARB_STARVE_EN.
module exu_alu_arb
    import exu_alu_arb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TAGW = ALU_ARB_TAGW
`ifdef EXU_ALU_ARB_STARVE_EN
   ,parameter int STARVE_LIM = 8
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            flush,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  alu_pkt_t        r0_ap,
    input  logic [TAGW-1:0] r0_tag,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    input  alu_pkt_t        r1_ap,
    input  logic [TAGW-1:0] r1_tag,
    output logic            alu_valid,
    output logic            alu_enable,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output alu_pkt_t        alu_ap,
    input  logic [XLEN-1:0] alu_out,
    output logic            rsp0_valid,
    output logic [TAGW-1:0] rsp0_tag,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp1_valid,
    output logic [TAGW-1:0] rsp1_tag,
    output logic [XLEN-1:0] rsp1_data
);

    logic          g0, g1, r1_pri, kill0, retire;
    arb_inflight_t if_q, if_d;

`ifdef EXU_ALU_ARB_STARVE_EN
    exu_arb_age #(.STARVE_LIM(STARVE_LIM)) u_age (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .req    (r1_valid),
        .gnt    (g1),
        .starve (r1_pri)
    );
`else
    assign r1_pri = 1'b0;
`endif

    // Grants are gated by rst so every output reads zero while reset is held.
    always_comb begin
        g0 = ~rst & ~freeze & r0_valid & ~flush & ~(r1_pri & r1_valid);
        g1 = ~rst & ~freeze & r1_valid & ~g0;
    end

    assign r0_ready   = g0;
    assign r1_ready   = g1;
    assign alu_valid  = g0 | g1;
    assign alu_enable = g0 | g1;
    assign alu_a      = rst ? '0 : (g1 ? r1_a : r0_a);
    assign alu_b      = rst ? '0 : (g1 ? r1_b : r0_b);
    assign alu_ap     = if_q.ap;

    assign kill0 = flush & (if_q.id == ARB_R0);

    // Frozen: entry holds unless flush kills an r0 op. Unfrozen: reload on grant or empty out.
    always_comb begin
        if_d = if_q;
        if (freeze) begin
            if (kill0) begin
                if_d = '0;
            end
        end else if (g0 || g1) begin
            if_d.v   = 1'b1;
            if_d.id  = g1 ? ARB_R1 : ARB_R0;
            if_d.tag = g1 ? ALU_ARB_TAGW'(r1_tag) : ALU_ARB_TAGW'(r0_tag);
            if_d.ap  = g1 ? r1_ap : r0_ap;
        end else begin
            if_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_q <= '0;
        end else begin
            if_q <= if_d;
        end
    end

    assign retire     = if_q.v & ~freeze & ~kill0;
    assign rsp0_valid = retire & (if_q.id == ARB_R0);
    assign rsp1_valid = retire & (if_q.id == ARB_R1);
    assign rsp0_tag   = rsp0_valid ? TAGW'(if_q.tag) : '0;
    assign rsp1_tag   = rsp1_valid ? TAGW'(if_q.tag) : '0;
    assign rsp0_data  = rsp0_valid ? alu_out : '0;
    assign rsp1_data  = rsp1_valid ? alu_out : '0;

endmodule

// File: tb/tb_exu_alu_arb.sv
// Directed bench for exu_alu_arb with a behavioural ALU (operand flops + packet-decoded result).
module tb_exu_alu_arb;
    import exu_alu_arb_pkg::*;

    localparam int XLEN = 64;
    localparam int TAGW = 4;
    localparam alu_pkt_t P_ADD = 8'b1000_0000;
    localparam alu_pkt_t P_SUB = 8'b0100_0000;
    localparam alu_pkt_t P_NONE = 8'b0000_0000;

    logic            clk = 1'b0;
    logic            rst, freeze, flush;
    logic            r0_valid, r0_ready, r1_valid, r1_ready;
    logic [XLEN-1:0] r0_a, r0_b, r1_a, r1_b;
    alu_pkt_t        r0_ap, r1_ap, alu_ap;
    logic [TAGW-1:0] r0_tag, r1_tag, rsp0_tag, rsp1_tag;
    logic            alu_valid, alu_enable, rsp0_valid, rsp1_valid;
    logic [XLEN-1:0] alu_a, alu_b, alu_out, rsp0_data, rsp1_data;
    logic [XLEN-1:0] fa = '0, fb = '0;
    int              checks = 0, failures = 0;

    exu_alu_arb #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ap(r0_ap), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ap(r1_ap), .r1_tag(r1_tag),
        .alu_valid(alu_valid), .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_ap(alu_ap),
        .alu_out(alu_out),
        .rsp0_valid(rsp0_valid), .rsp0_tag(rsp0_tag), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_tag(rsp1_tag), .rsp1_data(rsp1_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_enable) begin
            fa <= alu_a;
            fb <= alu_b;
        end
    end

    always_comb begin
        alu_out = '0;
        if (alu_ap.add)       alu_out = fa + fb;
        else if (alu_ap.sub)  alu_out = fa - fb;
        else if (alu_ap.land) alu_out = fa & fb;
        else if (alu_ap.lor)  alu_out = fa | fb;
        else if (alu_ap.lxor) alu_out = fa ^ fb;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0_valid = 1'b0; r1_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        r0_valid = 1'b1; r0_a = 64'd9; r0_b = 64'd9; r0_ap = P_ADD; r0_tag = 4'd1;
        r1_valid = 1'b1; r1_a = 64'd2; r1_b = 64'd1; r1_ap = P_SUB; r1_tag = 4'd2;
        step(); step(); #4;
        checks++; if (r0_ready !== 1'b0) begin failures++; $display("FAIL reset_r0_ready got=%0h exp=0", r0_ready); end
        checks++; if (r1_ready !== 1'b0) begin failures++; $display("FAIL reset_r1_ready got=%0h exp=0", r1_ready); end
        checks++; if (alu_valid !== 1'b0 || alu_enable !== 1'b0) begin failures++; $display("FAIL reset_alu_valid got=%0h/%0h exp=0/0", alu_valid, alu_enable); end
        checks++; if (alu_a !== '0 || alu_ap !== P_NONE) begin failures++; $display("FAIL reset_alu_a_ap got=%0h/%0h exp=0/0", alu_a, alu_ap); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h/%0h exp=0/0", rsp0_valid, rsp1_valid); end
        step(); rst = 1'b0; idle();
        step();
    endtask

    task automatic test_single();
        step(); r0_valid = 1'b1; r0_a = 64'd5; r0_b = 64'd7; r0_ap = P_ADD; r0_tag = 4'd3; #4;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%0h/%0h exp=1/0", r0_ready, r1_ready); end
        checks++; if (alu_valid !== 1'b1 || alu_enable !== 1'b1) begin failures++; $display("FAIL single_alu_valid got=%0h/%0h exp=1/1", alu_valid, alu_enable); end
        checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7) begin failures++; $display("FAIL single_operands got=%0h/%0h exp=5/7", alu_a, alu_b); end
        step(); r0_valid = 1'b0; #4;
        checks++; if (rsp0_valid !== 1'b1 || rsp0_tag !== 4'd3 || rsp0_data !== 64'd12) begin failures++; $display("FAIL single_rsp0 got=%0h/%0h/%0h exp=1/3/c", rsp0_valid, rsp0_tag, rsp0_data); end
        checks++; if (rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_rsp1 got=%0h exp=0", rsp1_valid); end
        checks++; if (alu_ap !== P_ADD) begin failures++; $display("FAIL single_alu_ap got=%0h exp=%0h", alu_ap, P_ADD); end
        step(); #4;
        checks++; if (rsp0_valid !== 1'b0 || rsp0_data !== '0 || alu_ap !== P_NONE) begin failures++; $display("FAIL single_idle got=%0h/%0h/%0h exp=0/0/0", rsp0_valid, rsp0_data, alu_ap); end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) begin
            step();
            r0_valid = 1'b1; r0_a = 64'(i + 1); r0_b = 64'd10; r0_ap = P_ADD; r0_tag = 4'(i);
            r1_valid = 1'b1; r1_a = 64'd100; r1_b = 64'd1; r1_ap = P_SUB; r1_tag = 4'd7;
            #4;
            checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL prio_ready[%0d] got=%0h/%0h exp=1/0", i, r0_ready, r1_ready); end
            if (i > 0) begin
                checks++; if (rsp0_valid !== 1'b1 || rsp0_tag !== 4'(i - 1) || rsp0_data !== 64'(i + 10)) begin failures++; $display("FAIL prio_rsp0[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, rsp0_valid, rsp0_tag, rsp0_data, i - 1, i + 10); end
            end
        end
        step(); r0_valid = 1'b0; #4;
        checks++; if (rsp0_valid !== 1'b1 || rsp0_tag !== 4'd2 || rsp0_data !== 64'd13) begin failures++; $display("FAIL prio_rsp0_last got=%0h/%0h/%0h exp=1/2/d", rsp0_valid, rsp0_tag, rsp0_data); end
        checks++; if (r1_ready !== 1'b1 || alu_a !== 64'd100) begin failures++; $display("FAIL prio_r1_grant got=%0h/%0h exp=1/64", r1_ready, alu_a); end
        step(); r1_valid = 1'b0; #4;
        checks++; if (rsp1_valid !== 1'b1 || rsp1_tag !== 4'd7 || rsp1_data !== 64'd99 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL prio_rsp1 got=%0h/%0h/%0h/%0h exp=1/7/63/0", rsp1_valid, rsp1_tag, rsp1_data, rsp0_valid); end
        step();
    endtask

`ifdef EXU_ALU_ARB_STARVE_EN
    task automatic test_starve();
        for (int k = 1; k <= 9; k++) begin
            step();
            r0_valid = 1'b1; r0_a = 64'(k); r0_b = 64'd0; r0_ap = P_ADD; r0_tag = 4'(k);
            r1_valid = 1'b1; r1_a = 64'd50; r1_b = 64'd8; r1_ap = P_SUB; r1_tag = 4'd4;
            #4;
            if (k < 9) begin
                checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL starve_wait[%0d] got=%0h/%0h exp=1/0", k, r0_ready, r1_ready); end
            end else begin
                checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b1) begin failures++; $display("FAIL starve_force got=%0h/%0h exp=0/1", r0_ready, r1_ready); end
            end
        end
        step(); r1_valid = 1'b0; #4;
        checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL starve_resume got=%0h exp=1", r0_ready); end
        checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 64'd42 || rsp1_tag !== 4'd4) begin failures++; $display("FAIL starve_rsp1 got=%0h/%0h/%0h exp=1/2a/4", rsp1_valid, rsp1_data, rsp1_tag); end
        step(); idle();
        step();
    endtask
`endif

    task automatic test_freeze();
        step(); r1_valid = 1'b1; r1_a = 64'd20; r1_b = 64'd8; r1_ap = P_SUB; r1_tag = 4'd5; #4;
        checks++; if (r1_ready !== 1'b1) begin failures++; $display("FAIL freeze_issue got=%0h exp=1", r1_ready); end
        for (int j = 0; j < 2; j++) begin
            step(); r1_valid = 1'b0; freeze = 1'b1; r0_valid = 1'b1; r0_a = 64'd77; r0_ap = P_ADD; #4;
            checks++; if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL freeze_no_rsp[%0d] got=%0h/%0h exp=0/0", j, rsp1_valid, rsp0_valid); end
            checks++; if (r0_ready !== 1'b0 || alu_valid !== 1'b0) begin failures++; $display("FAIL freeze_no_grant[%0d] got=%0h/%0h exp=0/0", j, r0_ready, alu_valid); end
        end
        step(); freeze = 1'b0; r0_valid = 1'b0; #4;
        checks++; if (rsp1_valid !== 1'b1 || rsp1_tag !== 4'd5 || rsp1_data !== 64'd12) begin failures++; $display("FAIL freeze_release got=%0h/%0h/%0h exp=1/5/c", rsp1_valid, rsp1_tag, rsp1_data); end
        step(); #4;
        checks++; if (rsp1_valid !== 1'b0) begin failures++; $display("FAIL freeze_single_rsp got=%0h exp=0", rsp1_valid); end
    endtask

    task automatic test_flush();
        step(); r0_valid = 1'b1; r0_a = 64'd1; r0_b = 64'd2; r0_ap = P_ADD; r0_tag = 4'd9; #4;
        checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL flush_issue got=%0h exp=1", r0_ready); end
        step(); flush = 1'b1; r0_a = 64'd40;
        r1_valid = 1'b1; r1_a = 64'd30; r1_b = 64'd4; r1_ap = P_SUB; r1_tag = 4'd6; #4;
        checks++; if (rsp0_valid !== 1'b0 || rsp0_data !== '0) begin failures++; $display("FAIL flush_kill_rsp0 got=%0h/%0h exp=0/0", rsp0_valid, rsp0_data); end
        checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b1 || alu_a !== 64'd30) begin failures++; $display("FAIL flush_grant got=%0h/%0h/%0h exp=0/1/1e", r0_ready, r1_ready, alu_a); end
        step(); idle(); #4;
        checks++; if (rsp1_valid !== 1'b1 || rsp1_tag !== 4'd6 || rsp1_data !== 64'd26 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL flush_rsp1 got=%0h/%0h/%0h/%0h exp=1/6/1a/0", rsp1_valid, rsp1_tag, rsp1_data, rsp0_valid); end
        step();
    endtask

    task automatic test_flush_freeze();
        step(); r0_valid = 1'b1; r0_a = 64'd2; r0_b = 64'd3; r0_ap = P_ADD; r0_tag = 4'd2;
        step(); r0_valid = 1'b0; freeze = 1'b1; flush = 1'b1; #4;
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL ff_frozen got=%0h exp=0", rsp0_valid); end
        step(); freeze = 1'b0; flush = 1'b0; #4;
        checks++; if (rsp0_valid !== 1'b0 || alu_ap !== P_NONE) begin failures++; $display("FAIL ff_cleared got=%0h/%0h exp=0/0", rsp0_valid, alu_ap); end
        step();
    endtask

    task automatic test_reset_mid();
        step(); r0_valid = 1'b1; r0_a = 64'd3; r0_b = 64'd4; r0_ap = P_ADD; r0_tag = 4'd1; #4;
        checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL rstmid_issue got=%0h exp=1", r0_ready); end
        step(); r0_valid = 1'b0; rst = 1'b1; #1;
        checks++; if (rsp0_valid !== 1'b0 || rsp0_data !== '0 || alu_ap !== P_NONE) begin failures++; $display("FAIL rstmid_immediate got=%0h/%0h/%0h exp=0/0/0", rsp0_valid, rsp0_data, alu_ap); end
        step(); step(); rst = 1'b0; #4;
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL rstmid_release got=%0h exp=0", rsp0_valid); end
        step(); #4;
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0h/%0h exp=0/0", rsp0_valid, rsp1_valid); end
    endtask

    initial begin
        r0_a = '0; r0_b = '0; r0_ap = P_NONE; r0_tag = '0;
        r1_a = '0; r1_b = '0; r1_ap = P_NONE; r1_tag = '0;
        test_reset();
        test_single();
`ifdef EXU_ALU_ARB_STARVE_EN
        test_starve();
`else
        test_priority();
`endif
        test_freeze();
        test_flush();
        test_flush_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
